// File: rtl/operand_fetch.sv
// operand_fetch
//   Operand-fetch / issue stage between decode and execute. Decoded
//   instructions arrive over a valid/ready handshake, their source
//   registers are read from the register file combinationally, and the
//   instruction is held back while a read-after-write or write-after-write
//   hazard exists against a 32-entry pending-write scoreboard. Accepted
//   instructions are issued through a single-entry output register.
//   Writeback commits clear scoreboard bits.
//
// Configuration macro:
//   OPFETCH_BYPASS_EN - when defined, a writeback landing in the same cycle
//                       as a dependent instruction forwards wb_data into the
//                       operand and releases the hazard in that cycle.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid / in_ready          upstream handshake
//   in_rs1, in_rs2, in_rd        source / destination register addresses
//   in_use_rs1, in_use_rs2       source operand is actually read
//   in_writes_rd                 instruction writes in_rd
//   in_pc, in_ctrl               pass-through payload
//   rf_rs1, rf_rs2               register-file read addresses
//   rf_rv1, rf_rv2               register-file read data (combinational)
//   out_valid / out_ready        downstream handshake
//   out_op1, out_op2             captured operands
//   out_rd, out_writes_rd        destination info
//   out_pc, out_ctrl             pass-through payload
//   wb_valid, wb_rd, wb_data     writeback commit (also writes the RF)
//   sb_pending                   scoreboard; bit r = write to xr outstanding

module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic             in_writes_rd,
  input  logic [31:0]      in_pc,
  input  logic [CTRLW-1:0] in_ctrl,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  input  logic [XLEN-1:0]  rf_rv1,
  input  logic [XLEN-1:0]  rf_rv2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [4:0]       out_rd,
  output logic             out_writes_rd,
  output logic [31:0]      out_pc,
  output logic [CTRLW-1:0] out_ctrl,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [31:0]      sb_pending
);

  logic [31:0]     sb;
  logic [31:0]     sb_next;
  logic            fwd1;
  logic            fwd2;
  logic            fwd_rd;
  logic            src_haz1;
  logic            src_haz2;
  logic            waw_haz;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] op1_val;
  logic [XLEN-1:0] op2_val;

  assign rf_rs1     = in_rs1;
  assign rf_rs2     = in_rs2;
  assign sb_pending = sb;

  // Forwarding matches: a writeback to the same nonzero register in this
  // cycle. Without the bypass build they are tied off, so the mux below
  // always picks the register file.
`ifdef OPFETCH_BYPASS_EN
  assign fwd1   = wb_valid && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
  assign fwd2   = wb_valid && (wb_rd == in_rs2) && (in_rs2 != 5'd0);
  assign fwd_rd = wb_valid && (wb_rd == in_rd)  && (in_rd  != 5'd0);
`else
  assign fwd1   = 1'b0;
  assign fwd2   = 1'b0;
  assign fwd_rd = 1'b0;
`endif

  assign src_haz1 = in_use_rs1   && (in_rs1 != 5'd0) && sb[in_rs1] && !fwd1;
  assign src_haz2 = in_use_rs2   && (in_rs2 != 5'd0) && sb[in_rs2] && !fwd2;
  assign waw_haz  = in_writes_rd && (in_rd  != 5'd0) && sb[in_rd]  && !fwd_rd;
  assign hazard   = src_haz1 | src_haz2 | waw_haz;

  assign in_ready = rst_n && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Operand selection: x0 and unused sources read as zero; a same-cycle
  // writeback wins over the (stale) register-file read data.
  always_comb begin
    op1_val = '0;
    op2_val = '0;
    if (in_use_rs1 && in_rs1 != 5'd0)
      op1_val = fwd1 ? wb_data : rf_rv1;
    if (in_use_rs2 && in_rs2 != 5'd0)
      op2_val = fwd2 ? wb_data : rf_rv2;
  end

  // Scoreboard update: writeback clears first, accept sets afterwards so a
  // same-cycle set and clear of one bit leaves it set. Bit 0 never sets.
  always_comb begin
    sb_next = sb;
    if (wb_valid && wb_rd != 5'd0)
      sb_next[wb_rd] = 1'b0;
    if (accept && in_writes_rd && in_rd != 5'd0)
      sb_next[in_rd] = 1'b1;
  end

  // Scoreboard and output register. An accept always overwrites the output
  // register (it is only allowed when the register is empty or draining);
  // otherwise a downstream transfer empties it and the data fields hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb            <= '0;
      out_valid     <= 1'b0;
      out_op1       <= '0;
      out_op2       <= '0;
      out_rd        <= '0;
      out_writes_rd <= 1'b0;
      out_pc        <= '0;
      out_ctrl      <= '0;
    end else begin
      sb <= sb_next;
      if (accept) begin
        out_valid     <= 1'b1;
        out_op1       <= op1_val;
        out_op2       <= op2_val;
        out_rd        <= in_rd;
        out_writes_rd <= in_writes_rd;
        out_pc        <= in_pc;
        out_ctrl      <= in_ctrl;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//   Directed testbench for operand_fetch. Stimulus pushes the expected
//   issued instruction into a queue; a monitor pops and compares on every
//   downstream transfer. Handshake and scoreboard state are checked inline.
//   Honours OPFETCH_BYPASS_EN for the writeback-forwarding timing.

module tb_operand_fetch;

  localparam int XLEN  = 32;
  localparam int CTRLW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [4:0]       in_rd;
  logic             in_use_rs1;
  logic             in_use_rs2;
  logic             in_writes_rd;
  logic [31:0]      in_pc;
  logic [CTRLW-1:0] in_ctrl;
  logic [4:0]       rf_rs1;
  logic [4:0]       rf_rs2;
  logic [XLEN-1:0]  rf_rv1;
  logic [XLEN-1:0]  rf_rv2;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_op1;
  logic [XLEN-1:0]  out_op2;
  logic [4:0]       out_rd;
  logic             out_writes_rd;
  logic [31:0]      out_pc;
  logic [CTRLW-1:0] out_ctrl;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [31:0]      sb_pending;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] pc;
    logic [31:0] ctrl;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monExp;
  int          numChecks = 0;
  int          numFails  = 0;
  logic [31:0] regs[32];
  logic        x0Force = 1'b0;

  operand_fetch #(.XLEN(XLEN), .CTRLW(CTRLW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_use_rs1   (in_use_rs1),
    .in_use_rs2   (in_use_rs2),
    .in_writes_rd (in_writes_rd),
    .in_pc        (in_pc),
    .in_ctrl      (in_ctrl),
    .rf_rs1       (rf_rs1),
    .rf_rs2       (rf_rs2),
    .rf_rv1       (rf_rv1),
    .rf_rv2       (rf_rv2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op1      (out_op1),
    .out_op2      (out_op2),
    .out_rd       (out_rd),
    .out_writes_rd(out_writes_rd),
    .out_pc       (out_pc),
    .out_ctrl     (out_ctrl),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .sb_pending   (sb_pending)
  );

  always #5 clk = ~clk;

  // Register-file model: reset loads known contents, writeback writes at
  // the same edge the DUT clears its scoreboard bit. x0 can be forced to a
  // nonzero read value to prove the DUT zeroes it itself.
  assign rf_rv1 = (rf_rs1 == 5'd0) ? (x0Force ? 32'hFFFF_FFFF : 32'h0) : regs[rf_rs1];
  assign rf_rv2 = (rf_rs2 == 5'd0) ? (x0Force ? 32'hFFFF_FFFF : 32'h0) : regs[rf_rs2];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'h1000 + i;
      regs[1] <= 32'd5;
      regs[2] <= 32'd7;
    end else if (wb_valid && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic u1,
                               input logic u2, input logic wr,
                               input logic [31:0] pc);
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_rd        = rd;
    in_use_rs1   = u1;
    in_use_rs2   = u2;
    in_writes_rd = wr;
    in_pc        = pc;
    in_ctrl      = {16'hC0DE, pc[15:0]};
    in_valid     = 1'b1;
    #1;
  endtask

  task automatic pushExpected(input logic [31:0] op1, input logic [31:0] op2,
                              input logic [4:0] rd, input logic wr,
                              input logic [31:0] pc);
    exp_t e;
    e.op1  = op1;
    e.op2  = op2;
    e.rd   = rd;
    e.wr   = wr;
    e.pc   = pc;
    e.ctrl = {16'hC0DE, pc[15:0]};
    expQ.push_back(e);
  endtask

  task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    tick();
    wb_valid = 1'b0;
  endtask

  // Monitor: every downstream transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        numChecks++;
        numFails++;
        $display("[TB] FAIL unexpected_output: got pc %h expected no transfer", out_pc);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("mon_op1",  out_op1, monExp.op1);
        checkOutput("mon_op2",  out_op2, monExp.op2);
        checkOutput("mon_rd",   32'(out_rd), 32'(monExp.rd));
        checkOutput("mon_wr",   32'(out_writes_rd), 32'(monExp.wr));
        checkOutput("mon_pc",   out_pc, monExp.pc);
        checkOutput("mon_ctrl", out_ctrl, monExp.ctrl);
      end
    end
  end

  // Watchdog so a stuck run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_rs1       = '0;
    in_rs2       = '0;
    in_rd        = '0;
    in_use_rs1   = 1'b0;
    in_use_rs2   = 1'b0;
    in_writes_rd = 1'b0;
    in_pc        = '0;
    in_ctrl      = '0;
    out_ready    = 1'b1;
    wb_valid     = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;

    // Reset: in_ready low even with a valid, hazard-free request.
    tick();
    applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'h0);
    checkOutput("ready_in_reset", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sb", sb_pending, 32'h0);
    checkOutput("reset_out_pc", out_pc, 32'h0);

    // add x3,x1,x2
    applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'h100);
    pushExpected(32'd5, 32'd7, 5'd3, 1'b1, 32'h100);
    checkOutput("add_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("add_out_valid", 32'(out_valid), 32'd1);
    checkOutput("add_sb", sb_pending, 32'h0000_0008);

    // Reader of x3 stalls until the x3 writeback.
    applyStimulus(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h104);
    pushExpected(32'h2A, 32'h0, 5'd4, 1'b1, 32'h104);
    checkOutput("raw_stall0", 32'(in_ready), 32'd0);
    tick();
    checkOutput("raw_stall1", 32'(in_ready), 32'd0);
    tick();
    checkOutput("raw_stall2", 32'(in_ready), 32'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    wb_data  = 32'h2A;
    #1;
`ifdef OPFETCH_BYPASS_EN
    checkOutput("raw_wb_cycle_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b0;
`else
    checkOutput("raw_wb_cycle_ready", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    checkOutput("raw_after_wb_ready", 32'(in_ready), 32'd1);
    checkOutput("raw_after_wb_sb", sb_pending, 32'h0);
    tick();
    in_valid = 1'b0;
`endif
    checkOutput("raw_out_valid", 32'(out_valid), 32'd1);
    checkOutput("raw_sb", sb_pending, 32'h0000_0010);
    tick();
    writeback(5'd4, 32'h44);
    checkOutput("clear_x4_sb", sb_pending, 32'h0);

    // Backpressure: full output register blocks independent input.
    out_ready = 1'b0;
    applyStimulus(5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 32'h200);
    pushExpected(32'd5, 32'd7, 5'd6, 1'b1, 32'h200);
    tick();
    applyStimulus(5'd2, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 32'h204);
    pushExpected(32'd7, 32'd5, 5'd7, 1'b1, 32'h204);
    checkOutput("bp_ready0", 32'(in_ready), 32'd0);
    checkOutput("bp_valid0", 32'(out_valid), 32'd1);
    tick();
    checkOutput("bp_ready1", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_op1", out_op1, 32'd5);
    checkOutput("bp_hold_pc", out_pc, 32'h200);
    checkOutput("bp_sb", sb_pending, 32'h0000_0040);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_next_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_next_pc", out_pc, 32'h204);
    checkOutput("bp_next_sb", sb_pending, 32'h0000_00C0);
    tick();
    writeback(5'd6, 32'h66);
    writeback(5'd7, 32'h77);
    checkOutput("clear_x6_x7_sb", sb_pending, 32'h0);

    // x0 destination / source with x0 read data forced nonzero.
    x0Force = 1'b1;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h300);
    pushExpected(32'h0, 32'h0, 5'd0, 1'b1, 32'h300);
    checkOutput("x0_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    x0Force  = 1'b0;
    checkOutput("x0_sb", sb_pending, 32'h0);
    tick();

    // WAW on x5; unused rs2 (x2) must issue as zero.
    applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 32'h400);
    pushExpected(32'd5, 32'h0, 5'd5, 1'b1, 32'h400);
    tick();
    checkOutput("waw_first_sb", sb_pending, 32'h0000_0020);
    applyStimulus(5'd2, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 32'h404);
    pushExpected(32'd7, 32'h0, 5'd5, 1'b1, 32'h404);
    checkOutput("waw_stall0", 32'(in_ready), 32'd0);
    tick();
    checkOutput("waw_stall1", 32'(in_ready), 32'd0);
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    wb_data  = 32'h55;
    #1;
`ifdef OPFETCH_BYPASS_EN
    checkOutput("waw_wb_cycle_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b0;
`else
    checkOutput("waw_wb_cycle_ready", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    checkOutput("waw_after_wb_ready", 32'(in_ready), 32'd1);
    checkOutput("waw_after_wb_sb", sb_pending, 32'h0);
    tick();
    in_valid = 1'b0;
`endif
    checkOutput("waw_reset_bit", sb_pending, 32'h0000_0020);
    tick();

    // Reset while holding an instruction with x4 and x5 pending.
    out_ready = 1'b0;
    applyStimulus(5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h500);
    tick();
    in_valid = 1'b0;
    checkOutput("pre_rst_sb", sb_pending, 32'h0000_0030);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("post_rst_sb", sb_pending, 32'h0);
    checkOutput("post_rst_pc", out_pc, 32'h0);
    checkOutput("post_rst_op1", out_op1, 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Back-to-back independent writers: one per cycle, bits accumulate.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'(1 + i % 2), 5'(2 - i % 2), 5'(8 + i), 1'b1, 1'b1, 1'b1,
                    32'h600 + 32'(4 * i));
      pushExpected((i % 2 == 1) ? 32'd7 : 32'd5, (i % 2 == 1) ? 32'd5 : 32'd7,
                   5'(8 + i), 1'b1, 32'h600 + 32'(4 * i));
      checkOutput("b2b_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("b2b_sb", sb_pending, 32'h0000_0700);
    tick();
    tick();
    tick();
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
